// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped, write-back data cache.
package dcache_pkg;
  localparam int DCACHE_NUM_LINES    = 4;
  localparam int DCACHE_LINE_WIDTH   = 128;
  localparam int REG_FILE_ADDR_WIDTH = 5;
  localparam int PC_WIDTH            = 32;

  localparam int OFFSET_HI = 3;
  localparam int OFFSET_LO = 0;
  localparam int INDEX_HI  = 5;
  localparam int INDEX_LO  = 4;
  localparam int TAG_HI    = 31;
  localparam int TAG_LO    = 6;
  localparam int OFFSET_W  = OFFSET_HI - OFFSET_LO + 1;
  localparam int INDEX_W   = INDEX_HI - INDEX_LO + 1;
  localparam int TAG_W     = TAG_HI - TAG_LO + 1;

  typedef enum logic {SIZE_BYTE = 1'b0, SIZE_WORD = 1'b1} dcache_size_t;

  typedef struct packed {
    logic [31:0]  addr;
    dcache_size_t size;
    logic         is_store;
    logic [31:0]  data;
  } dcache_request_t;

  typedef enum logic [1:0] {IDLE = 2'd0, EVICT = 2'd1, FILL = 2'd2} dcache_state_t;
endpackage

// File: rtl/dcache_if.sv
// ALU-side request, write-back, bypass and memory-side signals of the data cache.
interface dcache_if;
  import dcache_pkg::*;
  logic                           req_dcache_valid;
  dcache_request_t                req_dcache_info;
  logic                           req_m_type_instr;
  logic                           req_r_type_instr;
  logic [REG_FILE_ADDR_WIDTH-1:0] req_dst_reg;
  logic [PC_WIDTH-1:0]            req_dcache_pc;
  logic                           stall_alu;
  logic                           wb_valid;
  logic                           wb_rf_write;
  logic [REG_FILE_ADDR_WIDTH-1:0] wb_dst_reg;
  logic [31:0]                    wb_data;
  logic [PC_WIDTH-1:0]            wb_pc;
  logic [31:0]                    cache_data_bypass;
  logic                           cache_data_bp_valid;
  logic                           xcpt_dcache_unaligned;
  logic                           req_mem_valid;
  logic                           req_mem_is_store;
  logic [31:0]                    req_mem_addr;
  logic [DCACHE_LINE_WIDTH-1:0]   req_mem_data;
  logic                           mem_rsp_valid;
  logic [DCACHE_LINE_WIDTH-1:0]   mem_rsp_data;

  modport master (
    output req_dcache_valid, req_dcache_info, req_m_type_instr, req_r_type_instr,
           req_dst_reg, req_dcache_pc, mem_rsp_valid, mem_rsp_data,
    input  stall_alu, wb_valid, wb_rf_write, wb_dst_reg, wb_data, wb_pc,
           cache_data_bypass, cache_data_bp_valid, xcpt_dcache_unaligned,
           req_mem_valid, req_mem_is_store, req_mem_addr, req_mem_data
  );
  modport slave (
    input  req_dcache_valid, req_dcache_info, req_m_type_instr, req_r_type_instr,
           req_dst_reg, req_dcache_pc, mem_rsp_valid, mem_rsp_data,
    output stall_alu, wb_valid, wb_rf_write, wb_dst_reg, wb_data, wb_pc,
           cache_data_bypass, cache_data_bp_valid, xcpt_dcache_unaligned,
           req_mem_valid, req_mem_is_store, req_mem_addr, req_mem_data
  );
endinterface

// File: rtl/dcache_tag_data_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port.
module dcache_tag_data_array
  import dcache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INDEX_W-1:0]           rd_idx,
  output logic                         rd_valid,
  output logic                         rd_dirty,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [DCACHE_LINE_WIDTH-1:0] rd_data,
  input  logic                         wr_en,
  input  logic [INDEX_W-1:0]           wr_idx,
  input  logic                         wr_valid,
  input  logic                         wr_dirty,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [DCACHE_LINE_WIDTH-1:0] wr_data
);
  logic [DCACHE_NUM_LINES-1:0]                        valid, dirty;
  logic [DCACHE_NUM_LINES-1:0][TAG_W-1:0]             tags;
  logic [DCACHE_NUM_LINES-1:0][DCACHE_LINE_WIDTH-1:0] lines;

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = lines[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
      tags  <= '0;
      lines <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= wr_valid;
      dirty[wr_idx] <= wr_dirty;
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/dcache_top.sv
// Direct-mapped write-back/write-allocate data cache with IDLE/EVICT/FILL miss FSM.
module dcache_top
  import dcache_pkg::*;
(
  input logic     clk,
  input logic     rst,
  dcache_if.slave bus
);
  dcache_state_t                state;
  dcache_request_t              info;
  logic [INDEX_W-1:0]           idx;
  logic [TAG_W-1:0]             tag;
  logic [OFFSET_W-1:0]          off;
  logic                         rd_valid, rd_dirty;
  logic [TAG_W-1:0]             rd_tag;
  logic [DCACHE_LINE_WIDTH-1:0] rd_data, merged;
  logic                         wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]             wr_tag;
  logic [DCACHE_LINE_WIDTH-1:0] wr_data;
  logic                         is_mem, unaligned, hit, accept, miss;
  logic [31:0]                  load_data;

  assign info      = bus.req_dcache_info;
  assign idx       = info.addr[INDEX_HI:INDEX_LO];
  assign tag       = info.addr[TAG_HI:TAG_LO];
  assign off       = info.addr[OFFSET_HI:OFFSET_LO];
  assign is_mem    = bus.req_dcache_valid & bus.req_m_type_instr;
  assign unaligned = is_mem & (info.size == SIZE_WORD) & (|off[1:0]);
  assign hit       = rd_valid & (rd_tag == tag);
  assign accept    = (state == IDLE) & bus.req_dcache_valid;
  assign miss      = accept & is_mem & ~unaligned & ~hit;
  // The held request keeps indexing the array during EVICT/FILL, so one read port suffices.
  assign bus.stall_alu = ~rst & ((state != IDLE) | miss);

  assign bus.cache_data_bypass   = bus.wb_data;
  assign bus.cache_data_bp_valid = bus.wb_valid & bus.wb_rf_write;

  always_comb begin
    merged    = rd_data;
    load_data = {24'b0, rd_data[{off, 3'b000} +: 8]};
    if (info.size == SIZE_WORD) begin
      merged[{off[3:2], 5'b00000} +: 32] = info.data;
      load_data = rd_data[{off[3:2], 5'b00000} +: 32];
    end else begin
      merged[{off, 3'b000} +: 8] = info.data[7:0];
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_valid = 1'b1;
    wr_dirty = 1'b1;
    wr_tag   = tag;
    wr_data  = merged;
    if (accept & is_mem & ~unaligned & hit & info.is_store) wr_en = 1'b1;
    if ((state == FILL) & bus.mem_rsp_valid) begin
      wr_en    = 1'b1;
      wr_dirty = 1'b0;
      wr_data  = bus.mem_rsp_data;
    end
  end

  dcache_tag_data_array u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_valid(wr_valid),
    .wr_dirty(wr_dirty),
    .wr_tag  (wr_tag),
    .wr_data (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      bus.wb_valid              <= 1'b0;
      bus.wb_rf_write           <= 1'b0;
      bus.wb_dst_reg            <= '0;
      bus.wb_data               <= '0;
      bus.wb_pc                 <= '0;
      bus.xcpt_dcache_unaligned <= 1'b0;
      bus.req_mem_valid         <= 1'b0;
      bus.req_mem_is_store      <= 1'b0;
      bus.req_mem_addr          <= '0;
      bus.req_mem_data          <= '0;
    end else begin
      bus.wb_valid              <= 1'b0;
      bus.wb_rf_write           <= 1'b0;
      bus.xcpt_dcache_unaligned <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bus.wb_dst_reg <= bus.req_dst_reg;
          bus.wb_pc      <= bus.req_dcache_pc;
          if (!bus.req_m_type_instr) begin
            bus.wb_valid    <= 1'b1;
            bus.wb_rf_write <= bus.req_r_type_instr;
            bus.wb_data     <= info.data;
          end else if (unaligned) begin
            bus.wb_valid              <= 1'b1;
            bus.wb_data               <= '0;
            bus.xcpt_dcache_unaligned <= 1'b1;
          end else if (hit) begin
            bus.wb_valid    <= 1'b1;
            bus.wb_rf_write <= ~info.is_store;
            bus.wb_data     <= info.is_store ? info.data : load_data;
          end else if (rd_valid & rd_dirty) begin
            state                <= EVICT;
            bus.req_mem_valid    <= 1'b1;
            bus.req_mem_is_store <= 1'b1;
            bus.req_mem_addr     <= {rd_tag, idx, 4'b0000};
            bus.req_mem_data     <= rd_data;
          end else begin
            state                <= FILL;
            bus.req_mem_valid    <= 1'b1;
            bus.req_mem_is_store <= 1'b0;
            bus.req_mem_addr     <= {info.addr[31:4], 4'b0000};
            bus.req_mem_data     <= '0;
          end
        end
        EVICT: if (bus.mem_rsp_valid) begin
          // Write-back acknowledged: reissue as a line fill for the requested address.
          state                <= FILL;
          bus.req_mem_is_store <= 1'b0;
          bus.req_mem_addr     <= {info.addr[31:4], 4'b0000};
          bus.req_mem_data     <= '0;
        end
        FILL: if (bus.mem_rsp_valid) begin
          state             <= IDLE;
          bus.req_mem_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_top.sv
// Directed bench for dcache_top: hits, misses with evict/fill, bypass, unaligned and reset abort.
module tb_dcache_top;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  dcache_if bus ();
  dcache_top dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] LINE_A = {32'h0C0C_0C0C, 32'h0808_0808, 32'hDEAD_BEEF, 32'h0000_0000};
  localparam logic [127:0] LINE_A_MOD = {32'h0C0C_0C0C, 32'h0808_0808, 32'hDEAD_ABEF, 32'h0000_0000};
  localparam logic [127:0] LINE_B = {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic r, input logic [31:0] addr,
                       input dcache_size_t sz, input logic st, input logic [31:0] data,
                       input logic [4:0] dst, input logic [31:0] pc);
    bus.req_dcache_valid = v;
    bus.req_m_type_instr = m;
    bus.req_r_type_instr = r;
    bus.req_dcache_info  = '{addr: addr, size: sz, is_store: st, data: data};
    bus.req_dst_reg      = dst;
    bus.req_dcache_pc    = pc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, SIZE_WORD, 1'b0, 32'h0, 5'd0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    repeat (3) tick();
    chk("rst_stall", bus.stall_alu, 1'b0);
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_mem_valid", bus.req_mem_valid, 1'b0);
    chk("rst_bp_valid", bus.cache_data_bp_valid, 1'b0);
    chk("rst_xcpt", bus.xcpt_dcache_unaligned, 1'b0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    rst = 1'b0;
    tick();

    // Cold load miss -> FILL at 0x100
    drive(1'b1, 1'b1, 1'b0, 32'h104, SIZE_WORD, 1'b0, 32'h0, 5'd3, 32'h40);
    #1 chk("miss1_stall_comb", bus.stall_alu, 1'b1);
    tick();
    chk("fill1_mem_valid", bus.req_mem_valid, 1'b1);
    chk("fill1_is_store", bus.req_mem_is_store, 1'b0);
    chk("fill1_addr", bus.req_mem_addr, 32'h100);
    chk("fill1_no_wb", bus.wb_valid, 1'b0);
    chk("fill1_stall", bus.stall_alu, 1'b1);
    tick();
    chk("fill1_held", bus.req_mem_valid, 1'b1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = LINE_A;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("fill1_done_mem_valid", bus.req_mem_valid, 1'b0);
    chk("fill1_done_no_wb", bus.wb_valid, 1'b0);
    chk("replay1_stall", bus.stall_alu, 1'b0);
    tick();
    chk("ld1_wb_valid", bus.wb_valid, 1'b1);
    chk("ld1_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    chk("ld1_rf_write", bus.wb_rf_write, 1'b1);
    chk("ld1_bp_valid", bus.cache_data_bp_valid, 1'b1);
    chk("ld1_bypass", bus.cache_data_bypass, 32'hDEAD_BEEF);
    chk("ld1_dst", bus.wb_dst_reg, 5'd3);
    chk("ld1_pc", bus.wb_pc, 32'h40);

    // Store byte hit, then load word and load byte hits
    drive(1'b1, 1'b1, 1'b0, 32'h105, SIZE_BYTE, 1'b1, 32'h0000_00AB, 5'd0, 32'h44);
    #1 chk("st_hit_stall", bus.stall_alu, 1'b0);
    tick();
    chk("st_wb_valid", bus.wb_valid, 1'b1);
    chk("st_rf_write", bus.wb_rf_write, 1'b0);
    chk("st_bp_valid", bus.cache_data_bp_valid, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h104, SIZE_WORD, 1'b0, 32'h0, 5'd4, 32'h48);
    tick();
    chk("ld2_wb_data", bus.wb_data, 32'hDEAD_ABEF);
    chk("ld2_rf_write", bus.wb_rf_write, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h107, SIZE_BYTE, 1'b0, 32'h0, 5'd6, 32'h4C);
    tick();
    chk("ldb_wb_data", bus.wb_data, 32'h0000_00DE);
    chk("ldb_no_mem", bus.req_mem_valid, 1'b0);

    // Conflict miss on dirty line -> EVICT 0x100, then FILL 0x500
    drive(1'b1, 1'b1, 1'b0, 32'h504, SIZE_WORD, 1'b0, 32'h0, 5'd7, 32'h50);
    #1 chk("miss2_stall_comb", bus.stall_alu, 1'b1);
    tick();
    chk("evict_mem_valid", bus.req_mem_valid, 1'b1);
    chk("evict_is_store", bus.req_mem_is_store, 1'b1);
    chk("evict_addr", bus.req_mem_addr, 32'h100);
    chk("evict_data", bus.req_mem_data, LINE_A_MOD);
    chk("evict_stall", bus.stall_alu, 1'b1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = '0;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("fill2_mem_valid", bus.req_mem_valid, 1'b1);
    chk("fill2_is_store", bus.req_mem_is_store, 1'b0);
    chk("fill2_addr", bus.req_mem_addr, 32'h500);
    chk("fill2_stall", bus.stall_alu, 1'b1);
    chk("fill2_no_wb", bus.wb_valid, 1'b0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = LINE_B;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("replay2_stall", bus.stall_alu, 1'b0);
    tick();
    chk("ld3_wb_data", bus.wb_data, 32'h5555_5555);
    chk("ld3_wb_valid", bus.wb_valid, 1'b1);

    // R-type and branch retire without memory traffic; stray rsp in IDLE ignored
    drive(1'b1, 1'b0, 1'b1, 32'h0, SIZE_WORD, 1'b0, 32'h1234, 5'd5, 32'h54);
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("rtype_wb_valid", bus.wb_valid, 1'b1);
    chk("rtype_rf_write", bus.wb_rf_write, 1'b1);
    chk("rtype_dst", bus.wb_dst_reg, 5'd5);
    chk("rtype_data", bus.wb_data, 32'h1234);
    chk("rtype_no_mem", bus.req_mem_valid, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, SIZE_WORD, 1'b0, 32'h99, 5'd1, 32'h58);
    tick();
    chk("branch_wb_valid", bus.wb_valid, 1'b1);
    chk("branch_rf_write", bus.wb_rf_write, 1'b0);
    chk("branch_bp_valid", bus.cache_data_bp_valid, 1'b0);

    // Unaligned word load
    drive(1'b1, 1'b1, 1'b0, 32'h102, SIZE_WORD, 1'b0, 32'h0, 5'd2, 32'h5C);
    #1 chk("unal_stall", bus.stall_alu, 1'b0);
    tick();
    chk("unal_xcpt", bus.xcpt_dcache_unaligned, 1'b1);
    chk("unal_wb_valid", bus.wb_valid, 1'b1);
    chk("unal_rf_write", bus.wb_rf_write, 1'b0);
    chk("unal_no_mem", bus.req_mem_valid, 1'b0);
    idle();
    tick();
    chk("unal_xcpt_clear", bus.xcpt_dcache_unaligned, 1'b0);

    // Reset mid-FILL aborts; afterwards the formerly cached 0x500 line misses
    drive(1'b1, 1'b1, 1'b0, 32'h204, SIZE_WORD, 1'b0, 32'h0, 5'd8, 32'h60);
    tick();
    chk("fill3_mem_valid", bus.req_mem_valid, 1'b1);
    chk("fill3_addr", bus.req_mem_addr, 32'h200);
    rst = 1'b1;
    #1;
    chk("abort_mem_valid", bus.req_mem_valid, 1'b0);
    chk("abort_stall", bus.stall_alu, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h504, SIZE_WORD, 1'b0, 32'h0, 5'd9, 32'h64);
    #1 chk("post_rst_miss_stall", bus.stall_alu, 1'b1);
    tick();
    chk("post_rst_mem_valid", bus.req_mem_valid, 1'b1);
    chk("post_rst_addr", bus.req_mem_addr, 32'h500);
    chk("post_rst_is_store", bus.req_mem_is_store, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
